// File: rtl/fixed_to_dec_if.sv
// Bundle of request, operand and digit-stream signals for fixed_to_dec.
// Handshake: valid/ready. A digit transfers on a rising clock edge where valid and ready are both high.
// Once valid is up, digit and last stay frozen until that edge. ready has no effect while valid is low.
interface fixed_to_dec_if #(
  parameter int WIDTH = 400
);
  logic             start;
  logic [WIDTH-1:0] binary;
  logic             ready;
  logic [7:0]       digit;
  logic             valid;
  logic             last;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, binary, ready,
    input  digit, valid, last, busy, done, err
  );

  modport slave (
    input  start, binary, ready,
    output digit, valid, last, busy, done, err
  );
endinterface

// File: rtl/fixed_to_dec.sv
// Converts an unsigned fixed-point operand into a stream of decimal digits.
// The stream is one integer digit followed by NDIGITS truncated fractional digits.
module fixed_to_dec #(
  parameter int WIDTH     = 400,
  parameter int FRAC_BITS = 396,
  parameter int NDIGITS   = 120,
  parameter int ASCII     = 0
) (
  input  logic          clk,
  input  logic          rst,
  fixed_to_dec_if.slave bus,
  output logic [2:0]    state_o
);
  localparam int INT_BITS = WIDTH - FRAC_BITS;
  localparam int CW       = $clog2(NDIGITS + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CHECK = 3'd1;
  localparam logic [2:0] EMIT  = 3'd2;
  localparam logic [2:0] MUL   = 3'd3;
  localparam logic [2:0] FIN   = 3'd4;

  generate
    if (INT_BITS < 1 || INT_BITS > 4) begin : g_bad_int_bits
      $error("fixed_to_dec: WIDTH-FRAC_BITS must be 1..4");
    end
  endgenerate

  logic [2:0]           state_q, state_d;
  logic [WIDTH-1:0]     bin_q, bin_d;
  logic [FRAC_BITS-1:0] frac_q, frac_d;
  logic [3:0]           dig_q, dig_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic [3:0]           int_part;
  logic [FRAC_BITS+3:0] prod;
  logic                 is_last;
  logic                 emit_w;

  assign int_part = 4'(bin_q[WIDTH-1:FRAC_BITS]);
  // frac*10 as a shift-add; the top nibble is the next digit, the rest is the new fraction
  assign prod     = ({4'b0000, frac_q} << 3) + ({4'b0000, frac_q} << 1);
  assign is_last  = (cnt_q == CW'(NDIGITS));
  assign emit_w   = (state_q == EMIT);

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    frac_d  = frac_q;
    dig_d   = dig_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          bin_d   = bus.binary;
          err_d   = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (int_part > 4'd9) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          dig_d   = int_part;
          frac_d  = bin_q[FRAC_BITS-1:0];
          cnt_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (bus.ready) begin
          state_d = is_last ? FIN : MUL;
        end
      end
      MUL: begin
        dig_d   = prod[FRAC_BITS+3:FRAC_BITS];
        frac_d  = prod[FRAC_BITS-1:0];
        cnt_d   = cnt_q + CW'(1);
        state_d = EMIT;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      frac_q  <= '0;
      dig_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      frac_q  <= frac_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // ASCII offset is applied only while a digit is presented, so idle/reset reads as zero
  assign bus.digit = (ASCII != 0 && emit_w) ? {4'h3, dig_q} : {4'h0, dig_q};
  assign bus.valid = emit_w;
  assign bus.last  = emit_w && is_last;
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == FIN);
  assign bus.err   = (state_q == FIN) && err_q;
  assign state_o   = state_q;
endmodule

// File: tb/tb_fixed_to_dec.sv
// Self-checking bench for fixed_to_dec: small-width instances under random operands and ready patterns.
// A full-width instance is run on the constant e, including a reset part-way through a digit stream.
module tb_fixed_to_dec;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  localparam logic [399:0] E_BIN = 400'h2B7E151628_AED2A6ABF7_158809CF4F_3C762E7160_F38B4DA56A_784D904519_0CFEF324E7_738926CFBE_5F4BF8D8D8_C31D763DA0;
  localparam int E_DIG [20] = '{2, 7, 1, 8, 2, 8, 1, 8, 2, 8, 4, 5, 9, 0, 4, 5, 2, 3, 5, 3};

  logic         s_start, s_ready;
  logic [7:0]   s_bin;
  logic         d_start, d_ready;
  logic [399:0] d_bin;

  fixed_to_dec_if #(.WIDTH(8))   if_a ();
  fixed_to_dec_if #(.WIDTH(8))   if_b ();
  fixed_to_dec_if #(.WIDTH(8))   if_c ();
  fixed_to_dec_if #(.WIDTH(400)) if_d ();

  assign if_a.start = s_start; assign if_a.binary = s_bin; assign if_a.ready = s_ready;
  assign if_b.start = s_start; assign if_b.binary = s_bin; assign if_b.ready = s_ready;
  assign if_c.start = s_start; assign if_c.binary = s_bin; assign if_c.ready = s_ready;
  assign if_d.start = d_start; assign if_d.binary = d_bin; assign if_d.ready = d_ready;

  logic [2:0] o_state [4];

  fixed_to_dec #(.WIDTH(8), .FRAC_BITS(4), .NDIGITS(3), .ASCII(0)) u_a (.clk(clk), .rst(rst), .bus(if_a.slave), .state_o(o_state[0]));
  fixed_to_dec #(.WIDTH(8), .FRAC_BITS(4), .NDIGITS(4), .ASCII(0)) u_b (.clk(clk), .rst(rst), .bus(if_b.slave), .state_o(o_state[1]));
  fixed_to_dec #(.WIDTH(8), .FRAC_BITS(4), .NDIGITS(3), .ASCII(1)) u_c (.clk(clk), .rst(rst), .bus(if_c.slave), .state_o(o_state[2]));
  fixed_to_dec u_d (.clk(clk), .rst(rst), .bus(if_d.slave), .state_o(o_state[3]));

  logic [3:0] o_valid, o_last, o_busy, o_done, o_err;
  logic [7:0] o_digit [4];

  assign o_valid[0] = if_a.valid; assign o_last[0] = if_a.last; assign o_busy[0] = if_a.busy;
  assign o_done[0]  = if_a.done;  assign o_err[0]  = if_a.err;  assign o_digit[0] = if_a.digit;
  assign o_valid[1] = if_b.valid; assign o_last[1] = if_b.last; assign o_busy[1] = if_b.busy;
  assign o_done[1]  = if_b.done;  assign o_err[1]  = if_b.err;  assign o_digit[1] = if_b.digit;
  assign o_valid[2] = if_c.valid; assign o_last[2] = if_c.last; assign o_busy[2] = if_c.busy;
  assign o_done[2]  = if_c.done;  assign o_err[2]  = if_c.err;  assign o_digit[2] = if_c.digit;
  assign o_valid[3] = if_d.valid; assign o_last[3] = if_d.last; assign o_busy[3] = if_d.busy;
  assign o_done[3]  = if_d.done;  assign o_err[3]  = if_d.err;  assign o_digit[3] = if_d.digit;

  // scoreboard state, one slot per instance; 8'hFF marks a digit whose value is not tabulated
  logic [7:0] exp_q [4][$];
  int         first_v [4];
  int         last_hs [4];
  int         hs_n    [4];
  bit         done_seen [4];
  logic       prev_v [4];
  logic       prev_hs [4];
  logic       prev_l [4];
  logic [7:0] prev_d [4];

  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // digit k of b/16 in decimal: floor(b * 10^k / 16) mod 10
  function automatic logic [7:0] model_digit(input logic [7:0] b, input int k, input bit asc);
    longint p;
    p = longint'(b);
    for (int j = 0; j < k; j++) p = p * 10;
    return 8'((p >> 4) % 10) + (asc ? 8'h30 : 8'h00);
  endfunction

  task automatic drive(input bit big, input logic st, input logic rd);
    if (big) begin
      d_start = st; d_ready = rd;
    end else begin
      s_start = st; s_ready = rd;
    end
  endtask

  task automatic check_reset(input int i);
    check("rst_valid", o_valid[i], 0);
    check("rst_last",  o_last[i],  0);
    check("rst_busy",  o_busy[i],  0);
    check("rst_done",  o_done[i],  0);
    check("rst_err",   o_err[i],   0);
    check("rst_digit", o_digit[i], 0);
    check("rst_state", o_state[i], 0);
  endtask

  task automatic observe(input int i, input int cyc, input int rmode, input logic rd, input bit is_err);
    logic [7:0] e;
    if (cyc == 1) check("busy_after_start", o_busy[i], 1);
    if (o_valid[i]) begin
      if (exp_q[i].size() == 0) begin
        check("unexpected_valid", o_valid[i], 0);
      end else begin
        if (first_v[i] < 0) begin
          first_v[i] = cyc;
          check("first_valid_latency", cyc, 2);
        end
        if (prev_v[i] && !prev_hs[i]) begin
          check("hold_digit", o_digit[i], prev_d[i]);
          check("hold_last", o_last[i], prev_l[i]);
        end
        if (rd) begin
          e = exp_q[i].pop_front();
          if (e == 8'hFF) check("digit_range", o_digit[i] <= 8'd9, 1);
          else check("digit", o_digit[i], e);
          check("last", o_last[i], exp_q[i].size() == 0);
          if (rmode == 0 && last_hs[i] >= 0) check("digit_spacing", cyc - last_hs[i], 2);
          last_hs[i] = cyc;
          hs_n[i]++;
        end
      end
    end
    if (o_done[i]) begin
      if (done_seen[i]) begin
        check("done_pulse_width", o_done[i], 0);
      end else begin
        done_seen[i] = 1'b1;
        check("err_flag", o_err[i], is_err);
        check("digits_left", exp_q[i].size(), 0);
        if (is_err) check("err_done_latency", cyc, 2);
        else check("done_after_last", cyc - last_hs[i], 1);
      end
    end
    prev_v[i]  = o_valid[i];
    prev_hs[i] = o_valid[i] && rd;
    prev_d[i]  = o_digit[i];
    prev_l[i]  = o_last[i];
  endtask

  // rmode: 0 ready held high, 1 random ready, 2 five-cycle stall on the second digit
  task automatic run(input bit big, input logic [399:0] b, input int rmode, input int rst_at);
    int   lo, hi, cyc, stall;
    bit   is_err, all_done;
    logic rd, st;
    lo = big ? 3 : 0;
    hi = big ? 3 : 2;
    is_err = !big && (b[7:4] > 4'd9);
    for (int i = lo; i <= hi; i++) begin
      exp_q[i].delete();
      first_v[i] = -1; last_hs[i] = -1; hs_n[i] = 0; done_seen[i] = 1'b0;
      prev_v[i] = 1'b0; prev_hs[i] = 1'b0; prev_l[i] = 1'b0; prev_d[i] = 8'h00;
    end
    if (big) begin
      for (int k = 0; k < 121; k++) exp_q[3].push_back(k < 20 ? 8'(E_DIG[k]) : 8'hFF);
    end else if (!is_err) begin
      for (int k = 0; k < 4; k++) begin
        exp_q[0].push_back(model_digit(b[7:0], k, 1'b0));
        exp_q[2].push_back(model_digit(b[7:0], k, 1'b1));
      end
      for (int k = 0; k < 5; k++) exp_q[1].push_back(model_digit(b[7:0], k, 1'b0));
    end
    @(negedge clk);
    rd = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    if (big) d_bin = b; else s_bin = b[7:0];
    drive(big, 1'b1, rd);
    cyc = 0; stall = 5; all_done = 1'b0;
    while (!all_done && cyc < 800) begin
      @(negedge clk);
      cyc++;
      st = 1'b0;
      rd = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc == 1) begin
        if (big) d_bin = ~b; else s_bin = 8'($urandom);
      end
      if (rmode == 2 && hs_n[lo] == 1 && o_valid[lo] && stall > 0) begin
        rd = 1'b0;
        st = (stall == 3);
        stall--;
      end
      if (rmode == 1 && hs_n[lo] == 1) st = 1'($urandom_range(0, 1));
      if (rst_at >= 0 && hs_n[lo] == rst_at && o_valid[lo]) begin
        drive(big, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        for (int i = lo; i <= hi; i++) check_reset(i);
        rst = 1'b0;
        return;
      end
      drive(big, st, rd);
      #1;
      all_done = 1'b1;
      for (int i = lo; i <= hi; i++) begin
        observe(i, cyc, rmode, rd, is_err);
        if (!done_seen[i]) all_done = 1'b0;
      end
    end
    if (!all_done) check("timeout", all_done, 1);
    @(negedge clk);
    #1;
    for (int i = lo; i <= hi; i++) begin
      check("busy_after_done", o_busy[i], 0);
      check("done_after_done", o_done[i], 0);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1;
    s_start = 1'b0; s_ready = 1'b0; s_bin = 8'h00;
    d_start = 1'b0; d_ready = 1'b0; d_bin = '0;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) check_reset(i);
    rst = 1'b0;

    run(1'b0, 400'h28, 0, -1);
    run(1'b0, 400'h1F, 0, -1);
    run(1'b0, 400'hA0, 0, -1);
    run(1'b0, 400'h28, 2, -1);
    repeat (40) run(1'b0, 400'($urandom_range(0, 255)), int'($urandom_range(0, 2)), -1);

    run(1'b1, E_BIN, 0, 9);
    d_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      #1;
      check("no_resume_valid", o_valid[3], 0);
      check("no_resume_busy", o_busy[3], 0);
    end
    run(1'b1, E_BIN, 1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/fixed_to_dec.md
FIXED_TO_DEC -- requirements
Module: fixed_to_dec

Interface
REQ-001 Parameter WIDTH, default 400: total width of the unsigned fixed-point input.
REQ-002 Parameter FRAC_BITS, default 396: number of fractional bits. INT_BITS = WIDTH-FRAC_BITS SHALL be 1..4; other values are a compile-time error.
REQ-003 Parameter NDIGITS, default 120: number of fractional decimal digits emitted.
REQ-004 Parameter ASCII, default 0: 0 = digit carries the binary value 0..9; 1 = digit carries ASCII 0x30..0x39.
REQ-005 One clock, clk; reset rst is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 start  input  1  one-cycle conversion request; sampled only in IDLE.
REQ-009 binary  input  WIDTH  fixed-point operand; sampled only on an accepted start.
REQ-010 digit  output  8  current decimal digit; upper bits are zero when ASCII=0.
REQ-011 valid  output  1  digit is valid.
REQ-012 ready  input  1  consumer accepts the digit; a handshake occurs when valid & ready on a rising edge.
REQ-013 last  output  1  asserted together with valid on the final digit.
REQ-014 busy  output  1  high from an accepted start until done.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 err  output  1  high with done when the integer part exceeds 9.

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, CHECK, EMIT, MUL, FIN.
REQ-018 IDLE: start=1 SHALL latch binary into an internal register, set busy=1 and go to CHECK. start=0 SHALL stay in IDLE.
REQ-019 CHECK, integer part (top INT_BITS bits) > 9: go to FIN with the error flag set; no digit is emitted.
REQ-020 CHECK, integer part <= 9: load the digit register with the integer part, load the fraction register with the low FRAC_BITS bits, and go to EMIT. The first valid SHALL therefore rise 2 cycles after the start edge.
REQ-021 EMIT: valid=1, and digit and last SHALL be held stable until the handshake.
REQ-022 EMIT handshake: if the digit was the last one, go to FIN; otherwise go to MUL.
REQ-023 MUL, single cycle:
- p = frac*10, computed as (frac<<3)+(frac<<1) on FRAC_BITS+4 bits.
- The next digit is p[FRAC_BITS+3:FRAC_BITS].
- The new frac is p[FRAC_BITS-1:0].
- The digit counter increments, and the FSM goes to EMIT.
REQ-024 Digits are truncated, never rounded. Total digits = 1 integer + NDIGITS fractional; last SHALL be asserted on fractional digit NDIGITS.
REQ-025 FIN: done=1 for exactly one cycle, err = error flag, busy=0 from the next cycle, then return to IDLE.
REQ-026 start while busy SHALL be ignored; the in-flight conversion continues unaffected.
REQ-027 ready while valid=0 SHALL have no effect.
REQ-028 ready held high SHALL sustain one digit every 2 cycles.
REQ-029 The digit counter SHALL be sized clog2(NDIGITS+1) bits and SHALL NOT wrap within a conversion.
REQ-030 ASCII=1 SHALL add 0x30 at the output only; internal arithmetic is unchanged.

Reset
REQ-031 rst=1 SHALL force IDLE on the next edge from any state, including mid-stream and in EMIT with ready low.
REQ-032 After reset: digit=0, valid=0, last=0, busy=0, done=0, err=0, digit counter=0.
REQ-033 No partial stream SHALL resume after reset; a new start is required.

Verification
REQ-034 WIDTH=8, FRAC_BITS=4, NDIGITS=3, ready=1, binary=0x28 (2.5), start pulse:
- digits 2,5,0,0 are accepted on consecutive EMIT cycles 2 cycles apart;
- last is set with the 4th digit only;
- done pulses 1 cycle after the last handshake, with err=0.
REQ-035 Same parameters, binary=0x1F (1.9375):
- digits are 1,9,3,7;
- then with NDIGITS=4 the digits are 1,9,3,7,5 and the stream ends.
REQ-036 binary=0xA0 (integer part 10): no valid is ever asserted; done=1 and err=1 in the same cycle, 2 cycles after start; busy returns to 0.
REQ-037 Backpressure, binary=0x28: hold ready=0 for 5 cycles during the 2nd digit.
- valid=1 and digit=5 stay stable throughout;
- a start pulse during the stall is ignored;
- the stream completes unchanged once ready=1.
REQ-038 ASCII=1, binary=0x28: digits are 0x32,0x35,0x30,0x30.
REQ-039 Default parameters, binary = 400-bit e (0x2B7E1516...): the first 20 digits are 2,7,1,8,2,8,1,8,2,8,4,5,9,0,4,5,2,3,5,3. rst during digit 10 returns all outputs to their reset values next cycle, and a subsequent start restarts from digit 2.
